// File: rtl/usb_tx_sequencer.sv
// Transmit phase sequencer for the SIE: walks header, payload, CRC and EOP
// bit slots of one USB packet. It advances only on bit-slot strobes from the stuffer.
module usb_tx_sequencer #(
  parameter int LEN_W    = 14,
  parameter int HDR_BITS = 16,
  parameter int EOP_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       pkt_kind,
  input  logic [LEN_W-1:0] payload_bits,
  input  logic             bit_en,
  input  logic             abort,
  output logic [1:0]       sel,
  output logic             stream_adv,
  output logic             crc_clr,
  output logic             crc_en,
  output logic             crc_shift,
  output logic             token_pkt,
  output logic             data_pkt,
  output logic             eop,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [1:0] KIND_TOK  = 2'b00;
  localparam logic [1:0] KIND_DATA = 2'b01;
  localparam logic [1:0] KIND_HS   = 2'b10;
  localparam logic [1:0] KIND_RSV  = 2'b11;
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] EOP_LAST   = CNT_W'(EOP_BITS - 1);
  localparam logic [CNT_W-1:0] CRC5_LAST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] CRC16_LAST = CNT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAYLOAD, S_CRC, S_EOP, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       kind_q;
  logic [LEN_W-1:0] len_q;
  logic             aborted_q;
  logic             abort_hit;
  logic             adv;
  logic             accept;
  logic [CNT_W-1:0] len_last;

  assign abort_hit = abort && (state != S_IDLE);
  // every bit-slot strobe is suppressed in a cycle that abandons the packet
  assign adv       = bit_en && !abort;
  assign accept    = (state == S_IDLE) && start && (pkt_kind != KIND_RSV);
  assign len_last  = {1'b0, len_q} - CNT_W'(1);
  assign aborted   = aborted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      kind_q    <= 2'b00;
      len_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted_q <= abort_hit;
      if (accept) begin
        kind_q <= pkt_kind;
        len_q  <= payload_bits;
      end
      if (state_nxt != state) cnt <= '0;
      else if (bit_en && busy) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    sel        = 2'b11;
    stream_adv = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_shift  = 1'b0;
    token_pkt  = 1'b0;
    data_pkt   = 1'b0;
    eop        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          crc_clr   = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        busy       = 1'b1;
        sel        = 2'b00;
        stream_adv = adv;
        if (adv && cnt == HDR_LAST) begin
          if (kind_q == KIND_HS) state_nxt = S_EOP;
          else if (len_q == '0) begin
            // zero-length payload: the mux strobe rides on the last header bit
            token_pkt = (kind_q == KIND_TOK);
            data_pkt  = (kind_q == KIND_DATA);
            state_nxt = S_CRC;
          end else state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        busy       = 1'b1;
        sel        = 2'b00;
        stream_adv = adv;
        crc_en     = adv;
        if (adv && cnt == len_last) begin
          token_pkt = (kind_q == KIND_TOK);
          data_pkt  = (kind_q == KIND_DATA);
          state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        busy      = 1'b1;
        sel       = (kind_q == KIND_TOK) ? 2'b01 : 2'b10;
        crc_shift = adv;
        if (adv && cnt == ((kind_q == KIND_TOK) ? CRC5_LAST : CRC16_LAST))
          state_nxt = S_EOP;
      end
      S_EOP: begin
        busy = 1'b1;
        eop  = 1'b1;
        if (adv && cnt == EOP_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = !abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

endmodule
